// File: rtl/cxu_pkg.sv
// cxu_pkg: shared widths and the in-order response tag type for the
// CXU dispatcher.
//   CXU_*_W   : payload field widths of the CPU-side CXU port.
//   cxu_tag_t : one outstanding command. err=1 means the command had no
//               populated target and completes with an error response.
//               idx is the CXU that owns the response.
package cxu_pkg;

  localparam int CXU_DATA_W  = 32;
  localparam int CXU_FUNC_W  = 3;
  localparam int CXU_STATE_W = 3;
  localparam int CXU_ID_W    = 4;

  typedef struct packed {
    logic                err;
    logic [CXU_ID_W-1:0] idx;
  } cxu_tag_t;

endpackage

// File: rtl/cxu_tag_fifo.sv
// cxu_tag_fifo: small synchronous FIFO that records the issue order of
// outstanding commands.
//   clk, reset : clock, asynchronous active-low reset (clears pointers/count)
//   push, din  : write one element (ignored when full)
//   pop, dout  : dout is the head element; pop removes it (ignored when empty)
//   full/empty : occupancy flags
//   count      : number of stored elements
// There is no push/pop bypass: a push while full is dropped even if a pop
// happens in the same cycle. The caller never pushes while full.
module cxu_tag_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only read when count_q says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cxu_dispatch.sv
// cxu_dispatch: routes one CPU-side CXU command/response stream to N_CXU
// downstream CXUs and returns responses strictly in issue order.
//   clk, reset           : clock, asynchronous active-low reset
//   cmd_*                : upstream command (valid/ready + payload)
//   rsp_*                : upstream response (valid/ready + result, error)
//   cxu_cmd_*            : downstream command, one-hot valid, broadcast payload
//   cxu_rsp_*            : downstream responses, one 32-bit slice per CXU
//   outstanding          : number of dispatched commands awaiting response
// A command whose cxu_id has no populated CXU is never sent downstream; it
// completes through the tag FIFO as an error response with a zero result.
module cxu_dispatch
  import cxu_pkg::*;
#(
  parameter int N_CXU = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_payload_function_id,
  input  logic [31:0]                cmd_payload_inputs_0,
  input  logic [31:0]                cmd_payload_inputs_1,
  input  logic [2:0]                 cmd_payload_state_id,
  input  logic [3:0]                 cmd_payload_cxu_id,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_payload_outputs_0,
  output logic                       rsp_payload_error,
  output logic [N_CXU-1:0]           cxu_cmd_valid,
  input  logic [N_CXU-1:0]           cxu_cmd_ready,
  output logic [2:0]                 cxu_cmd_payload_function_id,
  output logic [31:0]                cxu_cmd_payload_inputs_0,
  output logic [31:0]                cxu_cmd_payload_inputs_1,
  output logic [2:0]                 cxu_cmd_payload_state_id,
  input  logic [N_CXU-1:0]           cxu_rsp_valid,
  output logic [N_CXU-1:0]           cxu_rsp_ready,
  input  logic [32*N_CXU-1:0]        cxu_rsp_payload_outputs_0,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam logic [CXU_ID_W:0] N_CXU_V = (CXU_ID_W+1)'(N_CXU);

  // Pending register: one command waiting for dispatch.
  logic                   pend_valid_q, pend_valid_d;
  logic [CXU_FUNC_W-1:0]  pend_func_q,  pend_func_d;
  logic [CXU_DATA_W-1:0]  pend_in0_q,   pend_in0_d;
  logic [CXU_DATA_W-1:0]  pend_in1_q,   pend_in1_d;
  logic [CXU_STATE_W-1:0] pend_state_q, pend_state_d;
  logic [CXU_ID_W-1:0]    pend_id_q,    pend_id_d;

  logic      tgt_ok, sel_cmd_ready, dispatch, accept, pop;
  logic      fifo_full, fifo_empty;
  cxu_tag_t  push_tag, head_tag;
  logic      sel_rsp_valid;
  logic [CXU_DATA_W-1:0] sel_rsp_data;

  assign tgt_ok = ({1'b0, pend_id_q} < N_CXU_V);

  // Dispatch side. A full FIFO holds cxu_cmd_valid low so a CXU never
  // accepts a command whose tag could not be recorded.
  always_comb begin
    cxu_cmd_valid = '0;
    for (int i = 0; i < N_CXU; i++) begin
      if (pend_valid_q && tgt_ok && !fifo_full && (pend_id_q == CXU_ID_W'(i)))
        cxu_cmd_valid[i] = 1'b1;
    end
  end

  assign sel_cmd_ready = |(cxu_cmd_valid & cxu_cmd_ready);
  assign dispatch      = pend_valid_q & ~fifo_full & (~tgt_ok | sel_cmd_ready);
  // Gated by reset so the port reads 0 while reset is held.
  assign cmd_ready     = reset & (~pend_valid_q | dispatch);
  assign accept        = cmd_valid & cmd_ready;

  assign cxu_cmd_payload_function_id = pend_func_q;
  assign cxu_cmd_payload_inputs_0    = pend_in0_q;
  assign cxu_cmd_payload_inputs_1    = pend_in1_q;
  assign cxu_cmd_payload_state_id    = pend_state_q;

  always_comb begin
    push_tag.err = ~tgt_ok;
    push_tag.idx = tgt_ok ? pend_id_q : '0;
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_func_d  = pend_func_q;
    pend_in0_d   = pend_in0_q;
    pend_in1_d   = pend_in1_q;
    pend_state_d = pend_state_q;
    pend_id_d    = pend_id_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_func_d  = cmd_payload_function_id;
      pend_in0_d   = cmd_payload_inputs_0;
      pend_in1_d   = cmd_payload_inputs_1;
      pend_state_d = cmd_payload_state_id;
      pend_id_d    = cmd_payload_cxu_id;
    end else if (dispatch) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q <= 1'b0;
      pend_func_q  <= '0;
      pend_in0_q   <= '0;
      pend_in1_q   <= '0;
      pend_state_q <= '0;
      pend_id_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_func_q  <= pend_func_d;
      pend_in0_q   <= pend_in0_d;
      pend_in1_q   <= pend_in1_d;
      pend_state_q <= pend_state_d;
      pend_id_q    <= pend_id_d;
    end
  end

  cxu_tag_fifo #(
    .DEPTH (DEPTH),
    .T     (cxu_tag_t)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dispatch),
    .din   (push_tag),
    .pop   (pop),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // Response side: only the CXU named by the head tag is listened to, so
  // any other CXU's response waits until its own tag reaches the head.
  always_comb begin
    sel_rsp_valid = 1'b0;
    sel_rsp_data  = '0;
    cxu_rsp_ready = '0;
    for (int i = 0; i < N_CXU; i++) begin
      if (head_tag.idx == CXU_ID_W'(i)) begin
        sel_rsp_valid    = cxu_rsp_valid[i];
        sel_rsp_data     = cxu_rsp_payload_outputs_0[32*i +: 32];
        cxu_rsp_ready[i] = rsp_ready & ~fifo_empty & ~head_tag.err;
      end
    end
  end

  assign rsp_valid             = ~fifo_empty & (head_tag.err | sel_rsp_valid);
  assign rsp_payload_outputs_0 = (fifo_empty | head_tag.err) ? '0 : sel_rsp_data;
  assign rsp_payload_error     = ~fifo_empty & head_tag.err;
  assign pop                   = rsp_valid & rsp_ready;

endmodule
